// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and helpers for the memory bridge: transfer/burst/response
// encodings, burst beat counts, next-beat address and write-strobe generation.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    // Helpers work on the widest supported address/strobe; callers truncate.
    localparam int MAX_AW   = 64;
    localparam int MAX_STRB = 16;

    function automatic logic ahb_xfer(input htrans_e t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

    function automatic logic [4:0] ahb_beats(input hburst_e b);
        case (b)
            HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            default:                      return 5'd0;
        endcase
    endfunction

    function automatic logic ahb_is_wrap(input hburst_e b);
        return (b == HBURST_WRAP4) || (b == HBURST_WRAP8) || (b == HBURST_WRAP16);
    endfunction

    function automatic logic [MAX_AW-1:0] ahb_next_addr(input logic [MAX_AW-1:0] addr,
                                                        input logic [2:0]        hsize,
                                                        input hburst_e           hburst);
        logic [MAX_AW-1:0] step;
        logic [MAX_AW-1:0] incr;
        logic [MAX_AW-1:0] win_mask;
        step = MAX_AW'(1) << hsize;
        incr = addr + step;
        if (ahb_is_wrap(hburst)) begin
            win_mask = (MAX_AW'(ahb_beats(hburst)) << hsize) - MAX_AW'(1);
            return (addr & ~win_mask) | (incr & win_mask);
        end
        return incr;
    endfunction

    function automatic logic [MAX_STRB-1:0] ahb_wstrb(input logic [MAX_AW-1:0] addr,
                                                      input logic [2:0]        hsize,
                                                      input int                dw);
        logic [31:0] lanes;
        logic [31:0] base;
        base  = (32'd1 << (32'd1 << hsize)) - 32'd1;
        lanes = addr[31:0] & 32'(dw / 8 - 1);
        return MAX_STRB'(base << lanes[4:0]);
    endfunction

endpackage

// File: rtl/ahb_burst_tracker.sv
// Follows an open AHB burst: expected next SEQ address and beats taken so far.
// seq_ok says whether the SEQ beat currently on the bus is a legal continuation.
module ahb_burst_tracker
    import ahb_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic          sample,
    input  logic [1:0]    htrans,
    input  logic [AW-1:0] haddr,
    input  logic [2:0]    hsize,
    input  logic [2:0]    hburst,
    output logic          seq_ok
);

    logic          open_q;
    logic [AW-1:0] exp_addr_q;
    logic [4:0]    beat_cnt_q;
    logic [4:0]    beat_lim_q;
    hburst_e       burst_q;

    logic [AW-1:0] next_nonseq;
    logic [AW-1:0] next_seq;

    assign next_nonseq = AW'(ahb_next_addr(MAX_AW'(haddr), hsize, hburst_e'(hburst)));
    assign next_seq    = AW'(ahb_next_addr(MAX_AW'(haddr), hsize, burst_q));

    // A limit of zero is undefined-length INCR: no beat ceiling.
    assign seq_ok = open_q && (haddr == exp_addr_q) &&
                    ((beat_lim_q == 5'd0) || (beat_cnt_q < beat_lim_q));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            open_q     <= 1'b0;
            exp_addr_q <= '0;
            beat_cnt_q <= '0;
            beat_lim_q <= '0;
            burst_q    <= HBURST_SINGLE;
        end else if (sample) begin
            case (htrans_e'(htrans))
                HTRANS_NONSEQ: begin
                    open_q     <= (hburst_e'(hburst) != HBURST_SINGLE);
                    exp_addr_q <= next_nonseq;
                    beat_cnt_q <= 5'd1;
                    beat_lim_q <= ahb_beats(hburst_e'(hburst));
                    burst_q    <= hburst_e'(hburst);
                end
                HTRANS_SEQ: begin
                    // Advance from the beat's own address, even if it was wrong.
                    if (open_q) begin
                        exp_addr_q <= next_seq;
                        if (beat_cnt_q != 5'd31) beat_cnt_q <= beat_cnt_q + 5'd1;
                    end
                end
                HTRANS_IDLE: open_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ahb_mem_bridge.sv
// AHB-Lite slave that turns bus transfers into a single-outstanding valid/ready
// memory request, with size/alignment/burst checks and the two-cycle ERROR response.
module ahb_mem_bridge
    import ahb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int CHECK_BURST = 1
) (
    input  logic            hclk,
    input  logic            hresetn,
    input  logic            hsel,
    input  logic            hready,
    input  logic [AW-1:0]   haddr,
    input  logic [1:0]      htrans,
    input  logic            hwrite,
    input  logic [2:0]      hsize,
    input  logic [2:0]      hburst,
    input  logic [3:0]      hprot,
    input  logic [DW-1:0]   hwdata,
    output logic            hreadyout,
    output logic [1:0]      hresp,
    output logic [DW-1:0]   hrdata,
    output logic            req_valid,
    input  logic            req_ready,
    output logic            req_write,
    output logic [AW-1:0]   req_addr,
    output logic [DW-1:0]   req_wdata,
    output logic [DW/8-1:0] req_wstrb,
    input  logic [DW-1:0]   req_rdata,
    input  logic            req_error
);

    localparam int SW    = DW / 8;
    localparam int LG_SW = $clog2(SW);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ERR1, ST_ERR2} state_e;

    state_e          state_q, state_d, phase_st;
    hresp_e          hresp_d;
    logic            phase_end;
    logic            take;
    logic            seq_ok;
    logic            size_err, align_err, burst_err, beat_err;
    logic [AW-1:0]   align_mask;
    logic [SW-1:0]   wstrb_d;
    logic            cap_write;
    logic [AW-1:0]   cap_addr;
    logic [SW-1:0]   cap_wstrb;
    logic            unused_hprot;

    assign unused_hprot = ^hprot;

    // A new address phase can only be taken when our own data phase is ending.
    assign phase_end = (state_q == ST_ERR1)   ? 1'b0 :
                       (state_q == ST_ACCESS) ? (req_ready & ~req_error) : 1'b1;
    assign take      = hsel & hready & phase_end & ahb_xfer(htrans_e'(htrans));

    assign size_err   = (hsize > 3'(LG_SW));
    assign align_mask = AW'((32'd1 << hsize) - 32'd1);
    assign align_err  = |(haddr & align_mask);
    assign burst_err  = (CHECK_BURST != 0) && (htrans_e'(htrans) == HTRANS_SEQ) && !seq_ok;
    assign beat_err   = size_err | align_err | burst_err;

    assign wstrb_d = hwrite ? SW'(ahb_wstrb(MAX_AW'(haddr), hsize, DW)) : '0;

    ahb_burst_tracker #(.AW(AW)) u_tracker (
        .hclk    (hclk),
        .hresetn (hresetn),
        .sample  (hsel & hready & phase_end),
        .htrans  (htrans),
        .haddr   (haddr),
        .hsize   (hsize),
        .hburst  (hburst),
        .seq_ok  (seq_ok)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wstrb <= '0;
        end else if (take) begin
            cap_write <= hwrite;
            cap_addr  <= haddr;
            cap_wstrb <= wstrb_d;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path leaves a
    // variable unassigned and infers a latch.
    always_comb begin
        phase_st = take ? (beat_err ? ST_ERR1 : ST_ACCESS) : ST_IDLE;
        state_d  = state_q;
        unique case (state_q)
            ST_IDLE, ST_ERR2: state_d = phase_st;
            ST_ACCESS: begin
                if (req_ready) state_d = req_error ? ST_ERR1 : phase_st;
            end
            ST_ERR1: state_d = ST_ERR2;
        endcase
    end

    always_comb begin
        hreadyout = 1'b1;
        hresp_d   = HRESP_OKAY;
        req_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: ;
            ST_ACCESS: begin
                req_valid = 1'b1;
                hreadyout = req_ready & ~req_error;
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp_d   = HRESP_ERROR;
            end
            ST_ERR2: hresp_d = HRESP_ERROR;
        endcase
    end

    assign hresp     = hresp_d;
    assign req_write = cap_write;
    assign req_addr  = cap_addr;
    assign req_wstrb = cap_wstrb;
    assign req_wdata = hwdata;
    assign hrdata    = req_rdata;

endmodule

// File: tb/tb_ahb_mem_bridge.sv
// Cycle-table bench for ahb_mem_bridge: each row is one bus cycle of stimulus
// with the expected slave and backend outputs, plus a reset-mid-stall sequence.
module tb_ahb_mem_bridge;
    import ahb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          hclk = 1'b0;
    logic          hresetn;
    logic          hsel;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [DW-1:0] hwdata;
    logic          hreadyout;
    logic [1:0]    hresp;
    logic [DW-1:0] hrdata;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_wstrb;
    logic [DW-1:0] req_rdata;
    logic          req_error;

    always #5 hclk = ~hclk;

    // Single slave on the bus: HREADY is this slave's own HREADYOUT.
    ahb_mem_bridge #(.AW(AW), .DW(DW), .CHECK_BURST(1)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hsel      (hsel),
        .hready    (hreadyout),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hprot     (4'b0011),
        .hwdata    (hwdata),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .req_rdata (req_rdata),
        .req_error (req_error)
    );

    typedef struct {
        string       name;
        logic        hsel;
        logic [1:0]  htrans;
        logic [31:0] haddr;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [2:0]  hburst;
        logic [31:0] hwdata;
        logic        rdy;
        logic        rerr;
        logic [31:0] rdata;
        logic        e_hrdy;
        logic [1:0]  e_hresp;
        logic        e_valid;
        logic        e_write;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [1:0] tr, input logic [31:0] addr,
                                input logic wr, input logic [2:0] sz, input logic [2:0] bu,
                                input logic [31:0] wd, input logic rdy, input logic rerr,
                                input logic [31:0] rd, input logic eh, input logic [1:0] er,
                                input logic ev, input logic ew, input logic [31:0] ea,
                                input logic [3:0] es);
        vec_t v;
        v.name = name; v.hsel = 1'b1; v.htrans = tr; v.haddr = addr; v.hwrite = wr;
        v.hsize = sz; v.hburst = bu; v.hwdata = wd; v.rdy = rdy; v.rerr = rerr; v.rdata = rd;
        v.e_hrdy = eh; v.e_hresp = er; v.e_valid = ev; v.e_write = ew; v.e_addr = ea;
        v.e_strb = es;
        return v;
    endfunction

    task automatic drive_idle();
        hsel = 1'b1; htrans = HTRANS_IDLE; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
        hburst = HBURST_SINGLE; hwdata = '0; req_ready = 1'b0; req_error = 1'b0; req_rdata = '0;
    endtask

    task automatic apply(input vec_t v);
        hsel = v.hsel; htrans = v.htrans; haddr = v.haddr; hwrite = v.hwrite; hsize = v.hsize;
        hburst = v.hburst; hwdata = v.hwdata; req_ready = v.rdy; req_error = v.rerr;
        req_rdata = v.rdata;
        @(negedge hclk);
        check({v.name, " hreadyout"}, 32'(hreadyout), 32'(v.e_hrdy));
        check({v.name, " hresp"},     32'(hresp),     32'(v.e_hresp));
        check({v.name, " req_valid"}, 32'(req_valid), 32'(v.e_valid));
        if (v.e_valid) begin
            check({v.name, " req_write"}, 32'(req_write), 32'(v.e_write));
            check({v.name, " req_addr"},  req_addr,       v.e_addr);
            check({v.name, " req_wstrb"}, 32'(req_wstrb), 32'(v.e_strb));
            if (v.e_write) check({v.name, " req_wdata"}, req_wdata, v.hwdata);
            else if (v.rdy) check({v.name, " hrdata"}, hrdata, v.rdata);
        end
        @(posedge hclk);
        #1;
    endtask

    localparam logic [1:0] TI = HTRANS_IDLE;
    localparam logic [1:0] TN = HTRANS_NONSEQ;
    localparam logic [1:0] TS = HTRANS_SEQ;

    initial begin
        vec_t v;
        // hsel low: transfer belongs to another slave and must be ignored
        v = mk("H0", TN, 32'h10, 1, 2, HBURST_SINGLE, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        v.hsel = 1'b0;
        vecs.push_back(v);
        vecs.push_back(mk("H1", TI, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // single zero-wait word write
        vecs.push_back(mk("A0", TN, 32'h10, 1, 2, HBURST_SINGLE, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("A1", TI, 0, 0, 2, 0, 32'hDEADBEEF, 1, 0, 0, 1, 0, 1, 1, 32'h10, 4'hF));
        vecs.push_back(mk("A2", TI, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // byte read with three wait states
        vecs.push_back(mk("B0", TN, 32'h13, 0, 0, HBURST_SINGLE, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("B1", TI, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h13, 4'h0));
        vecs.push_back(mk("B2", TI, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h13, 4'h0));
        vecs.push_back(mk("B3", TI, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h13, 4'h0));
        vecs.push_back(mk("B4", TI, 0, 0, 2, 0, 0, 1, 0, 32'h11223344, 1, 0, 1, 0, 32'h13, 4'h0));
        vecs.push_back(mk("B5", TI, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // WRAP4 from 0x38, then an illegal fifth beat
        vecs.push_back(mk("C0", TN, 32'h38, 1, 2, HBURST_WRAP4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("C1", TS, 32'h3C, 1, 2, HBURST_WRAP4, 32'hC0, 1, 0, 0, 1, 0, 1, 1, 32'h38, 4'hF));
        vecs.push_back(mk("C2", TS, 32'h30, 1, 2, HBURST_WRAP4, 32'hC1, 1, 0, 0, 1, 0, 1, 1, 32'h3C, 4'hF));
        vecs.push_back(mk("C3", TS, 32'h34, 1, 2, HBURST_WRAP4, 32'hC2, 1, 0, 0, 1, 0, 1, 1, 32'h30, 4'hF));
        vecs.push_back(mk("C4", TS, 32'h38, 1, 2, HBURST_WRAP4, 32'hC3, 1, 0, 0, 1, 0, 1, 1, 32'h34, 4'hF));
        vecs.push_back(mk("C5", TI, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("C6", TI, 0, 0, 2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("C7", TI, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // INCR8 reads, third beat off by four, rest continue from it
        vecs.push_back(mk("D0", TN, 32'h100, 0, 2, HBURST_INCR8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("D1", TS, 32'h104, 0, 2, HBURST_INCR8, 0, 1, 0, 32'hA0, 1, 0, 1, 0, 32'h100, 0));
        vecs.push_back(mk("D2", TS, 32'h10C, 0, 2, HBURST_INCR8, 0, 1, 0, 32'hA1, 1, 0, 1, 0, 32'h104, 0));
        vecs.push_back(mk("D3", TS, 32'h110, 0, 2, HBURST_INCR8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("D4", TS, 32'h110, 0, 2, HBURST_INCR8, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("D5", TS, 32'h114, 0, 2, HBURST_INCR8, 0, 1, 0, 32'hA2, 1, 0, 1, 0, 32'h110, 0));
        vecs.push_back(mk("D6", TS, 32'h118, 0, 2, HBURST_INCR8, 0, 1, 0, 32'hA3, 1, 0, 1, 0, 32'h114, 0));
        vecs.push_back(mk("D7", TS, 32'h11C, 0, 2, HBURST_INCR8, 0, 1, 0, 32'hA4, 1, 0, 1, 0, 32'h118, 0));
        vecs.push_back(mk("D8", TI, 0, 0, 2, 0, 0, 1, 0, 32'hA5, 1, 0, 1, 0, 32'h11C, 0));
        vecs.push_back(mk("D9", TI, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // oversize, misaligned, then backend error on a good halfword
        vecs.push_back(mk("E0", TN, 32'h20, 1, 3, HBURST_SINGLE, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("E1", TI, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("E2", TN, 32'h01, 1, 1, HBURST_SINGLE, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("E3", TI, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("E4", TI, 0, 0, 2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("E5", TN, 32'h26, 1, 1, HBURST_SINGLE, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("E6", TI, 0, 0, 2, 0, 32'hBEEF0000, 1, 1, 0, 0, 0, 1, 1, 32'h26, 4'hC));
        vecs.push_back(mk("E7", TI, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("E8", TI, 0, 0, 2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        // SEQ with no open burst, then an undefined-length INCR of bytes
        vecs.push_back(mk("F0", TS, 32'h40, 0, 2, HBURST_INCR, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("F1", TI, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("F2", TN, 32'h41, 1, 0, HBURST_INCR, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("F3", TS, 32'h42, 1, 0, HBURST_INCR, 32'h0000AA00, 1, 0, 0, 1, 0, 1, 1, 32'h41, 4'h2));
        vecs.push_back(mk("F4", TI, 0, 0, 2, 0, 32'h00BB0000, 1, 0, 0, 1, 0, 1, 1, 32'h42, 4'h4));
        vecs.push_back(mk("F5", TI, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

        drive_idle();
        hresetn = 1'b0;
        repeat (2) @(posedge hclk);
        #1;
        check("reset hreadyout", 32'(hreadyout), 32'd1);
        check("reset hresp",     32'(hresp),     32'd0);
        check("reset req_valid", 32'(req_valid), 32'd0);
        hresetn = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Reset asserted in the middle of a stalled read
        hsel = 1'b1; htrans = TN; haddr = 32'h80; hwrite = 1'b0; hsize = 3'd2;
        hburst = HBURST_SINGLE; req_ready = 1'b0;
        @(negedge hclk);
        @(posedge hclk); #1;
        htrans = TI;
        @(negedge hclk);
        check("R stall req_valid", 32'(req_valid), 32'd1);
        check("R stall hreadyout", 32'(hreadyout), 32'd0);
        #2 hresetn = 1'b0;
        #1;
        check("R async hreadyout", 32'(hreadyout), 32'd1);
        check("R async req_valid", 32'(req_valid), 32'd0);
        check("R async hresp",     32'(hresp),     32'd0);
        @(posedge hclk); #1;
        @(posedge hclk); #1;
        hresetn = 1'b1;
        htrans = TN; haddr = 32'h84; hwrite = 1'b1; hsize = 3'd2;
        @(negedge hclk);
        check("R post idle req_valid", 32'(req_valid), 32'd0);
        @(posedge hclk); #1;
        htrans = TI; hwdata = 32'hCAFEF00D; req_ready = 1'b1;
        @(negedge hclk);
        check("R post req_valid", 32'(req_valid), 32'd1);
        check("R post req_addr",  req_addr,       32'h84);
        check("R post req_wstrb", 32'(req_wstrb), 32'hF);
        check("R post req_wdata", req_wdata,      32'hCAFEF00D);
        check("R post hreadyout", 32'(hreadyout), 32'd1);
        @(posedge hclk); #1;
        req_ready = 1'b0;
        @(negedge hclk);
        check("R post done", 32'(req_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ahb_mem_bridge.md
# ahb_mem_bridge

AHB-Lite slave front end that turns bus transfers into a single-outstanding, valid/ready memory request port, parametrised in address and data width. Replaces the fixed-width, single-beat register slaves: it generates byte strobes for any legal HSIZE and checks SEQ beat addresses against the HBURST sequence (INCR/WRAP/INCRn). It sits between the AHB interconnect and any SRAM or register backend, converting illegal transfers into the two-cycle AHB ERROR response.

## Interface
- AW, 32, address width (≥12)
- DW, 32, data width; 32, 64 or 128
- CHECK_BURST, 1, enables the SEQ address/beat-count checker; 0 means SEQ is treated as NONSEQ
- hclk  in  1  clock
- hresetn  in  1  asynchronous active-low reset
- hsel, hready  in  1  slave select, bus-wide HREADY
- haddr  in  AW  address; htrans in 2 (htrans_e); hwrite in 1; hsize in 3; hburst in 3 (hburst_e); hprot in 4 (ignored)
- hwdata  in  DW  write data (data phase)
- hreadyout  out  1  slave ready; hresp out 2 (hresp_e, OKAY/ERROR only); hrdata out DW
- req_valid  out  1  backend request; req_ready in 1 (completes the access, same cycle)
- req_write  out  1; req_addr out AW (byte address); req_wdata out DW; req_wstrb out DW/8
- req_rdata  in  DW  valid with req_ready on reads; req_error in 1 valid with req_ready

## Operation
- Transfer accepted when hsel & hready & ahb_xfer(htrans); address-phase signals captured into registers on that edge.
- Address-phase error checks (no backend request issued for failed beats): hsize > log2(DW/8); haddr not aligned to 1<<hsize; with CHECK_BURST, SEQ with no burst open, SEQ haddr ≠ expected address, or SEQ beyond the fixed beat count (4/8/16).
- Burst tracker: NONSEQ opens a burst (SINGLE opens none); expected next = haddr+(1<<hsize) for INCR*, wrapped within a (beats<<hsize)-byte aligned window for WRAP*. Every accepted beat, errored or not, advances the tracker from its own haddr. BUSY holds tracker state; IDLE or a NONSEQ closes/restarts it. INCR (undefined length) has no beat limit and no 1 KB check.
- FSM states: IDLE, ACCESS, ERR1, ERR2.
  - IDLE: hreadyout=1, hresp=OKAY. Good beat accepted → ACCESS; bad beat → ERR1.
  - ACCESS: req_valid=1, req_* driven from captured phase, req_wdata=hwdata. hreadyout=req_ready & ~req_error. On req_ready: req_error → ERR1; else the beat completes and the FSM goes to ACCESS/ERR1/IDLE per the pipelined next address phase sampled that same cycle.
  - ERR1: hreadyout=0, hresp=ERROR → ERR2. ERR2: hreadyout=1, hresp=ERROR; a new transfer sampled here is accepted normally (→ ACCESS/ERR1/IDLE).
- req_wstrb: (1<<(1<<hsize))-1 shifted left by haddr[log2(DW/8)-1:0]; all-zero on reads. hrdata = req_rdata passed through combinationally.

## Timing
- Reset: state IDLE, hreadyout=1, hresp=OKAY, req_valid=0, tracker closed, captured registers 0. hresetn is asserted asynchronously and released synchronously to hclk; reset mid-ACCESS drops req_valid immediately.
- Zero-wait access: address phase in cycle N, req_valid and the data phase in N+1; if req_ready=1 in N+1, hreadyout=1 in N+1.
- Backend stall k cycles → k wait states; req_* stable while req_valid & ~req_ready.
- Error: exactly two data-phase cycles (ERR1, ERR2), starting the cycle after the bad address phase or the cycle after the req_error handshake.
- Address phases presented while hready=0 are ignored (not captured).

## Structure
- Add to ahb_pkg: ahb_beats(hburst) → 0/4/8/16, ahb_next_addr(addr, hsize, hburst) and ahb_wstrb(addr, hsize, DW) functions; the FSM state enum stays local.
- One sub-module, ahb_burst_tracker: holds the open flag, expected address and beat count, and outputs seq_ok.

## Test plan
- Single 32-bit write haddr=0x10, hwdata=0xDEADBEEF, req_ready=1 → req_valid 1 cycle, req_wstrb=4'hF, hreadyout never low.
- Byte read hsize=0, haddr=0x13, req_ready delayed 3 cycles → 3 wait states, req_wstrb=0, hrdata=req_rdata when hreadyout=1.
- WRAP4 word burst from 0x38 → beats 0x38,0x3C,0x30,0x34 all OKAY; a fifth SEQ beat → ERR1/ERR2, no req_valid.
- INCR8 with third beat haddr off by 4 → that beat ERROR two cycles; the remaining beats, correctly continued from it, are OKAY.
- hsize=3 at DW=32, and a misaligned halfword at 0x01 → ERROR, no backend access; req_error=1 on a good beat → ERROR.
- Assert hresetn low mid-stall → hreadyout=1, req_valid=0 immediately; the first NONSEQ after release completes normally.
